// File: rtl/mont_exp_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mont_exp_ctrl_if : host request/result and Montgomery multiplier links   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface mont_exp_ctrl_if #(
   parameter int WIDTH  = 1024,
   parameter int ELEN_W = 11
);
   logic              start;
   logic [WIDTH-1:0]  in_x;
   logic [WIDTH-1:0]  in_r;
   logic [WIDTH-1:0]  in_m;
   logic [WIDTH-1:0]  in_e;
   logic [ELEN_W-1:0] in_elen;
   logic              mm_start;
   logic [WIDTH-1:0]  mm_a;
   logic [WIDTH-1:0]  mm_b;
   logic [WIDTH-1:0]  mm_m;
   logic [WIDTH:0]    mm_result;
   logic              mm_done;
   logic [WIDTH-1:0]  result;
   logic              busy;
   logic              done;

   modport slave (
      input  start, in_x, in_r, in_m, in_e, in_elen, mm_result, mm_done,
      output mm_start, mm_a, mm_b, mm_m, result, busy, done
   );

   modport master (
      output start, in_x, in_r, in_m, in_e, in_elen, mm_result, mm_done,
      input  mm_start, mm_a, mm_b, mm_m, result, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/mont_exp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mont_exp_ctrl : left-to-right binary Montgomery exponentiation sequencer |
// | Option MONT_EXP_SKIP_LEADING_ZEROS_EN skips squarings of A=R. Rev: 1.0   |
// +--------------------------------------------------------------------------+
module mont_exp_ctrl #(
   parameter int WIDTH  = 1024,
   parameter int ELEN_W = 11
) (
   input  wire logic        clk,
   input  wire logic        resetn,
   mont_exp_ctrl_if.slave   bus
);
   localparam int                c_IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [ELEN_W-1:0] c_ELEN_MAX = ELEN_W'(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SQR_START = 3'd1,
      S_SQR_WAIT  = 3'd2,
      S_MUL_START = 3'd3,
      S_MUL_WAIT  = 3'd4,
      S_NEXT      = 3'd5,
      S_FIN       = 3'd6
   } state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     x_q;
   logic [WIDTH-1:0]     e_q;
   logic [WIDTH-1:0]     a_q;
   logic [c_IDX_W-1:0]   idx_q;
   logic                 armed_q;
   logic                 mm_start_q;
   logic [WIDTH-1:0]     mm_a_q;
   logic [WIDTH-1:0]     mm_b_q;
   logic [WIDTH-1:0]     mm_m_q;
   logic [WIDTH-1:0]     result_q;
   logic                 busy_q;
   logic                 done_q;
`ifdef MONT_EXP_SKIP_LEADING_ZEROS_EN
   logic                 started_q;
`endif

   logic [ELEN_W-1:0]    w_elen_eff;
   logic [ELEN_W-1:0]    w_elen_m1;
   logic [WIDTH-1:0]     w_prod;
   logic                 w_unused_msb;
   logic                 w_ebit;
   logic                 w_last;
   logic                 w_accept;

   assign w_elen_eff   = (bus.in_elen > c_ELEN_MAX) ? c_ELEN_MAX : bus.in_elen;
   assign w_elen_m1    = w_elen_eff - 1'b1;
   assign w_prod       = bus.mm_result[WIDTH-1:0];
   assign w_unused_msb = bus.mm_result[WIDTH];
   assign w_ebit       = e_q[idx_q];
   assign w_last       = (idx_q == '0);
   // A done level still high from the previous operation must drop once before it counts.
   assign w_accept     = bus.mm_done & armed_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         x_q        <= '0;
         e_q        <= '0;
         a_q        <= '0;
         idx_q      <= '0;
         armed_q    <= 1'b0;
         mm_start_q <= 1'b0;
         mm_a_q     <= '0;
         mm_b_q     <= '0;
         mm_m_q     <= '0;
         result_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef MONT_EXP_SKIP_LEADING_ZEROS_EN
         started_q  <= 1'b0;
`endif
      end else begin
         mm_start_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  x_q    <= bus.in_x;
                  e_q    <= bus.in_e;
                  a_q    <= bus.in_r;
                  mm_m_q <= bus.in_m;
                  busy_q <= 1'b1;
`ifdef MONT_EXP_SKIP_LEADING_ZEROS_EN
                  started_q <= 1'b0;
`endif
                  if (w_elen_eff != '0) begin
                     idx_q   <= c_IDX_W'(w_elen_m1);
                     state_q <= S_NEXT;
                  end else begin
                     idx_q   <= '0;
                     state_q <= S_FIN;
                  end
               end
            end
            S_NEXT: begin
`ifdef MONT_EXP_SKIP_LEADING_ZEROS_EN
               // Until the first 1-bit, A is still R and MM(R,R)=R, so squaring is a no-op.
               if (started_q) begin
                  mm_start_q <= 1'b1;
                  mm_a_q     <= a_q;
                  mm_b_q     <= a_q;
                  state_q    <= S_SQR_START;
               end else if (w_ebit) begin
                  started_q  <= 1'b1;
                  mm_start_q <= 1'b1;
                  mm_a_q     <= a_q;
                  mm_b_q     <= x_q;
                  state_q    <= S_MUL_START;
               end else if (w_last) begin
                  state_q    <= S_FIN;
               end else begin
                  idx_q      <= idx_q - 1'b1;
               end
`else
               mm_start_q <= 1'b1;
               mm_a_q     <= a_q;
               mm_b_q     <= a_q;
               state_q    <= S_SQR_START;
`endif
            end
            S_SQR_START: begin
               armed_q <= ~bus.mm_done;
               state_q <= S_SQR_WAIT;
            end
            S_MUL_START: begin
               armed_q <= ~bus.mm_done;
               state_q <= S_MUL_WAIT;
            end
            S_SQR_WAIT, S_MUL_WAIT: begin
               if (!bus.mm_done) begin
                  armed_q <= 1'b1;
               end
               if (w_accept) begin
                  a_q     <= w_prod;
                  armed_q <= 1'b0;
                  if ((state_q == S_SQR_WAIT) && w_ebit) begin
                     mm_start_q <= 1'b1;
                     mm_a_q     <= w_prod;
                     mm_b_q     <= x_q;
                     state_q    <= S_MUL_START;
                  end else if (w_last) begin
                     result_q <= w_prod;
                     done_q   <= 1'b1;
                     busy_q   <= 1'b0;
                     state_q  <= S_FIN;
                  end else begin
                     idx_q   <= idx_q - 1'b1;
                     state_q <= S_NEXT;
                  end
               end
            end
            S_FIN: begin
               // Completion from a wait state already raised done; other paths raise it here.
               if (!done_q) begin
                  result_q <= a_q;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
               end
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.mm_start = mm_start_q;
   assign bus.mm_a     = mm_a_q;
   assign bus.mm_b     = mm_b_q;
   assign bus.mm_m     = mm_m_q;
   assign bus.result   = result_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule
`default_nettype wire

// File: tb/tb_mont_exp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mont_exp_ctrl : directed bench with a modular-multiply mock           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mont_exp_ctrl;
   localparam int W  = 8;
   localparam int EW = 4;
`ifdef MONT_EXP_SKIP_LEADING_ZEROS_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   int   errors = 0;
   int   checks = 0;

   mont_exp_ctrl_if #(.WIDTH(W), .ELEN_W(EW)) bus ();

   mont_exp_ctrl #(.WIDTH(W), .ELEN_W(EW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Mock multiplier: (a*b) mod m, done after 5 cycles, held mk_hold cycles.
   int         mk_cnt       = 0;
   int         mk_done_left = 0;
   int         mk_hold      = 1;
   bit         mk_msb       = 1'b0;
   logic [W-1:0] mk_a = '0, mk_b = '0, mk_m = '0;

   assign bus.mm_done = (mk_done_left != 0);

   always @(posedge clk) begin
      if (mk_done_left > 0) mk_done_left <= mk_done_left - 1;
      if (bus.mm_start) begin
         mk_cnt <= 5;
         mk_a   <= bus.mm_a;
         mk_b   <= bus.mm_b;
         mk_m   <= bus.mm_m;
      end else if (mk_cnt > 0) begin
         mk_cnt <= mk_cnt - 1;
         if (mk_cnt == 1) begin
            bus.mm_result <= {mk_msb, W'((int'(mk_a) * int'(mk_b)) % int'(mk_m))};
            mk_done_left  <= mk_hold;
         end
      end
   end

   task automatic do_start(input logic [W-1:0] x, r, m, e, input logic [EW-1:0] elen);
      @(posedge clk); #1;
      bus.in_x = x; bus.in_r = r; bus.in_m = m; bus.in_e = e; bus.in_elen = elen;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic run_wait(input int budget, output bit found, output int cyc,
                           output int pulses, output int unstable, output bit prev_mmd,
                           output logic [W-1:0] res);
      found = 1'b0; cyc = 0; pulses = 0; unstable = 0; prev_mmd = 1'b0; res = '0;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (bus.mm_start) pulses++;
         else if (mk_cnt > 0 && (bus.mm_a !== mk_a || bus.mm_b !== mk_b || bus.mm_m !== mk_m))
            unstable++;
         if (bus.done) begin
            found = 1'b1; cyc = k; res = bus.result;
            break;
         end
         prev_mmd = bus.mm_done;
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.in_x = '0; bus.in_r = '0; bus.in_m = '0; bus.in_e = '0; bus.in_elen = '0;
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({bus.busy, bus.done, bus.mm_start} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl got=%b want=000", {bus.busy, bus.done, bus.mm_start}); end
      checks++; if (bus.result !== '0) begin
         errors++; $display("FAIL reset_result got=%0d want=0", bus.result); end
      checks++; if ({bus.mm_a, bus.mm_b, bus.mm_m} !== '0) begin
         errors++; $display("FAIL reset_operands got=%h want=0", {bus.mm_a, bus.mm_b, bus.mm_m}); end
      resetn = 1'b1;
   endtask

   task automatic test_basic(input string nm, input logic [W-1:0] x, m, e, input logic [EW-1:0] elen,
                             input logic [W-1:0] exp_res, input int exp_pulses);
      bit found, pmd; int cyc, pulses, unst; logic [W-1:0] res;
      do_start(x, 8'd1, m, e, elen);
      run_wait(400, found, cyc, pulses, unst, pmd, res);
      checks++; if (!found) begin errors++; $display("FAIL %s_timeout got=no_done want=done", nm); end
      checks++; if (res !== exp_res) begin errors++; $display("FAIL %s_result got=%0d want=%0d", nm, res, exp_res); end
      checks++; if (pulses != exp_pulses) begin errors++; $display("FAIL %s_pulses got=%0d want=%0d", nm, pulses, exp_pulses); end
      checks++; if (unst != 0) begin errors++; $display("FAIL %s_stable got=%0d want=0", nm, unst); end
      if (exp_pulses != 0) begin
         checks++; if (pmd !== 1'b1) begin errors++; $display("FAIL %s_latency got=%b want=1", nm, pmd); end
      end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done got=%b want=0", nm, bus.busy); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_done_width got=%b want=0", nm, bus.done); end
      checks++; if (bus.result !== exp_res) begin errors++; $display("FAIL %s_result_hold got=%0d want=%0d", nm, bus.result, exp_res); end
   endtask

   task automatic test_elen_zero();
      bit found, pmd; int cyc, pulses, unst; logic [W-1:0] res;
      do_start(8'd3, 8'd7, 8'd13, 8'd5, 4'd0);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL elen0_busy got=%b want=1", bus.busy); end
      run_wait(20, found, cyc, pulses, unst, pmd, res);
      checks++; if (!found || cyc != 2) begin errors++; $display("FAIL elen0_latency got=%0d want=2", cyc); end
      checks++; if (pulses != 0) begin errors++; $display("FAIL elen0_pulses got=%0d want=0", pulses); end
      checks++; if (res !== 8'd7) begin errors++; $display("FAIL elen0_result got=%0d want=7", res); end
   endtask

   task automatic test_busy_start();
      bit fired = 1'b0, found = 1'b0; int pulses = 0, dones = 0, after = -1; logic [W-1:0] res = '0;
      int target = SKIP ? 1 : 2;
      do_start(8'd3, 8'd1, 8'd13, 8'd5, 4'd3);
      for (int k = 0; k < 400 && !found; k++) begin
         @(negedge clk);
         if (bus.mm_start) pulses++;
         if (bus.done) begin dones++; found = 1'b1; res = bus.result; end
         if (!fired && pulses == target && after < 0) after = 0;
         else if (after >= 0 && !fired) begin
            after++;
            if (after == 2) begin
               bus.in_x = 8'd5; bus.in_e = 8'd1; bus.in_elen = 4'd1; bus.start = 1'b1;
               fired = 1'b1;
               @(negedge clk);
               if (bus.mm_start) pulses++;
               bus.start = 1'b0;
            end
         end
      end
      checks++; if (res !== 8'd9) begin errors++; $display("FAIL busy_start_result got=%0d want=9", res); end
      checks++; if (pulses != (SKIP ? 4 : 5)) begin errors++; $display("FAIL busy_start_pulses got=%0d want=%0d", pulses, SKIP ? 4 : 5); end
      checks++; if (dones != 1) begin errors++; $display("FAIL busy_start_dones got=%0d want=1", dones); end
   endtask

   task automatic test_reset_mid();
      int pulses = 0, dones = 0;
      do_start(8'd3, 8'd1, 8'd13, 8'd5, 4'd3);
      for (int k = 0; k < 100 && pulses < (SKIP ? 2 : 1); k++) begin
         @(negedge clk);
         if (bus.mm_start) pulses++;
      end
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      #1;
      checks++; if ({bus.busy, bus.done, bus.mm_start} !== 3'b000 || {bus.mm_a, bus.mm_b, bus.mm_m, bus.result} !== '0) begin
         errors++; $display("FAIL reset_async got=%b/%h want=000/0", {bus.busy, bus.done, bus.mm_start},
                            {bus.mm_a, bus.mm_b, bus.mm_m, bus.result}); end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (12) begin @(negedge clk); if (bus.done) dones++; end
      checks++; if (dones != 0) begin errors++; $display("FAIL reset_no_done got=%0d want=0", dones); end
      test_basic("after_reset", 8'd3, 8'd13, 8'd5, 4'd3, 8'd9, SKIP ? 4 : 5);
   endtask

   initial begin
      test_reset();
      test_basic("e5_len3", 8'd3, 8'd13, 8'd5, 4'd3, 8'd9, SKIP ? 4 : 5);
      test_basic("e5_len8", 8'd3, 8'd13, 8'd5, 4'd8, 8'd9, SKIP ? 4 : 10);
      test_basic("clamp15", 8'd3, 8'd13, 8'd5, 4'd15, 8'd9, SKIP ? 4 : 10);
      test_basic("e0_len4", 8'd3, 8'd13, 8'd0, 4'd4, 8'd1, SKIP ? 0 : 4);
      mk_msb = 1'b1;
      test_basic("msb_set", 8'd7, 8'd11, 8'd6, 4'd3, 8'd4, SKIP ? 4 : 5);
      mk_msb = 1'b0;
      test_elen_zero();
      test_busy_start();
      repeat (12) @(negedge clk);
      test_reset_mid();
      mk_hold = 3;
      test_basic("held_done", 8'd3, 8'd13, 8'd5, 4'd3, 8'd9, SKIP ? 4 : 5);
      mk_hold = 1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
